// File: rtl/ham_15_11_pkg.sv
// Shared Hamming (15,11) constants, types and helpers used by both the
// encoder and the decoder of the pair.
package ham_15_11_pkg;

  localparam int HAM_N = 15;
  localparam int HAM_K = 11;
  localparam int HAM_R = 4;

  // Codeword position (1-based) carrying data bit d0..d10
  localparam int DATA_POS [0:HAM_K-1] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  typedef struct packed {
    logic [HAM_K-1:0] data;
    logic             err;
    logic [HAM_R-1:0] pos;
  } ham_dec_out_t;

  // s[k] covers every position whose 1-based index has bit k set
  function automatic logic [HAM_R-1:0] ham_syndrome(input logic [HAM_N-1:0] cw);
    logic [HAM_R-1:0] s;
    s = '0;
    for (int p = 1; p <= HAM_N; p++) begin
      for (int k = 0; k < HAM_R; k++) begin
        if (p[k]) s[k] = s[k] ^ cw[p-1];
      end
    end
    return s;
  endfunction

  function automatic logic [HAM_K-1:0] ham_extract(input logic [HAM_N-1:0] cw);
    logic [HAM_K-1:0] d;
    d = '0;
    for (int i = 0; i < HAM_K; i++) begin
      d[i] = cw[DATA_POS[i]-1];
    end
    return d;
  endfunction

endpackage

// File: rtl/ham_15_11_dec_core.sv
// Combinational correction and data extraction for one codeword, given its
// already-computed syndrome.
module ham_15_11_dec_core
  import ham_15_11_pkg::*;
(
  input  logic [HAM_N-1:0] cw_i,
  input  logic [HAM_R-1:0] syn_i,
  output ham_dec_out_t     out_o
);

  logic [HAM_N-1:0] fixed_cw;

  // The syndrome names the 1-based position to flip; zero flips nothing
  for (genvar gi = 0; gi < HAM_N; gi++) begin : g_flip
    assign fixed_cw[gi] = cw_i[gi] ^ (syn_i == HAM_R'(gi + 1));
  end

  always_comb begin
    out_o.data = ham_extract(fixed_cw);
    out_o.err  = |syn_i;
    out_o.pos  = syn_i;
  end

endmodule

// File: rtl/ham_15_11_dec.sv
// Two-stage Hamming (15,11) SEC decoder with valid/ready on both sides.
// Define HAM_15_11_DEC_ERR_CNT_EN to build the saturating corrected-error counter.
module ham_15_11_dec
  import ham_15_11_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [HAM_N-1:0]    data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [HAM_K-1:0]    data_o,
  output logic                err_o,
  output logic [HAM_R-1:0]    err_pos_o,
  output logic                valid_o,
  input  logic                ready_i,
  input  logic                cnt_clr_i,
  output logic [CNT_W-1:0]    err_cnt_o
);

  logic             s1_valid_q, s1_valid_d;
  logic [HAM_N-1:0] s1_cw_q, s1_cw_d;
  logic [HAM_R-1:0] s1_syn_q, s1_syn_d;
  logic             s2_valid_q, s2_valid_d;
  ham_dec_out_t     s2_q, s2_d;
  ham_dec_out_t     core_out;
  logic             s2_adv;
  logic             s1_load;

  // A stage may load when it is empty or its occupant leaves this cycle
  assign s2_adv  = ~s2_valid_q | ready_i;
  assign s1_load = ~s1_valid_q | s2_adv;
  assign ready_o = s1_load;

  ham_15_11_dec_core u_core (
    .cw_i  (s1_cw_q),
    .syn_i (s1_syn_q),
    .out_o (core_out)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cw_d    = s1_cw_q;
    s1_syn_d   = s1_syn_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s1_load) begin
      s1_valid_d = valid_i;
      if (valid_i) begin
        s1_cw_d  = data_i;
        s1_syn_d = ham_syndrome(data_i);
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_d = core_out;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_syn_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_cw_q    <= s1_cw_d;
      s1_syn_q   <= s1_syn_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
    end
  end

  assign valid_o   = s2_valid_q;
  assign data_o    = s2_q.data;
  assign err_o     = s2_q.err;
  assign err_pos_o = s2_q.pos;

`ifdef HAM_15_11_DEC_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             out_xfer;

  assign out_xfer = s2_valid_q & ready_i;

  // Clear wins over a same-cycle increment; the count sticks at all-ones
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cnt_clr_i) begin
      err_cnt_d = '0;
    end else if (out_xfer && s2_q.err && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
  assign err_cnt_o      = '0;
`endif

endmodule

// File: doc/ham_15_11_dec.md
Name: ham_15_11_dec

Overview:
- Pipelined Hamming (15,11) single-error-correcting decoder.
- Counterpart of ham_15_11_enc. Sits on the receive side of any link or storage path that carries ham_15_11_enc codewords.
- Accepts one 15-bit codeword per handshake. Returns 11 corrected data bits, an error flag and the error position.
- Optional saturating counter of corrected errors.

Parameters:
- CNT_W, 16, width of corrected-error counter (2..32).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- data_i  in  15  codeword. Bit i = codeword position i+1. Parity at positions 1,2,4,8 (indices 0,1,3,7). Data d0..d10 at positions 3,5,6,7,9,10,11,12,13,14,15.
- valid_i  in  1  data_i valid.
- ready_o  out  1  decoder can accept data_i.
- data_o  out  11  corrected data.
- err_o  out  1  non-zero syndrome; a correction was applied.
- err_pos_o  out  4  syndrome = flipped position (1..15), 0 if none.
- valid_o  out  1  data_o/err_o/err_pos_o valid.
- ready_i  in  1  downstream accepts.
- cnt_clr_i  in  1  synchronous clear of err_cnt_o.
- err_cnt_o  out  CNT_W  corrected-error count.

Behaviour:
- One clock; reset is asynchronous and active-high (clk_i, rst_i).
- Reset: valid_o=0, data_o=0, err_o=0, err_pos_o=0, err_cnt_o=0, both stage-valid flags 0. ready_o=1 after reset.
- Transfer rules:
  - Input transfer when valid_i & ready_o.
  - Output transfer when valid_o & ready_i.
  - Data must not change while valid_o=1 and ready_i=0.
- Stage 1 (syndrome):
  - Registers the codeword and syndrome s[3:0].
  - s[k] = XOR of all codeword positions whose index has bit k set, including the parity bit at position 2^k.
- Stage 2 (correct):
  - If s!=0, flips codeword position s.
  - Extracts d0..d10 to data_o, sets err_o=(s!=0), err_pos_o=s.
  - s pointing at a parity position still asserts err_o; data_o is unaffected.
- Latency: 2 cycles from input transfer to valid_o with no backpressure. Throughput: 1 word/cycle.
- Stall rules:
  - Each stage loads when it is empty or its contents move on that cycle.
  - ready_o = ~s1_valid | s2 advancing (~valid_o | ready_i), a combinational path from ready_i.
  - Full stall with both stages occupied: ready_o=0, no data lost, no duplication.
- Double-bit errors are not detectable. The decoder miscorrects per the syndrome (documented limitation).
- Reset asserted mid-operation: both stages are discarded immediately and asynchronously. No output is produced after release.

Optional Feature:
- Macro: HAM_15_11_DEC_ERR_CNT_EN.
- Defined:
  - err_cnt_o increments by 1 on each output transfer with err_o=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr_i clears it to 0 and takes priority over an increment in the same cycle.
- Undefined: no counter logic; err_cnt_o is tied to 0 and cnt_clr_i is ignored. Ports are present in both builds.

Decomposition:
- Package ham_15_11_pkg holds:
  - localparams HAM_N=15, HAM_K=11, HAM_R=4.
  - Position table DATA_POS[0:10] = {3,5,6,7,9,10,11,12,13,14,15}.
  - function ham_syndrome(codeword) and function ham_extract(codeword). The encoder shares these.
- Sub-module ham_15_11_dec_core: combinational correct/extract from codeword + syndrome, instantiated in stage 2.

Test Plan:
- data_i=15'h6350 (data 11'h63A), ready_i=1 -> 2 cycles later data_o=11'h63A, err_o=0, err_pos_o=0.
- data_i=15'h6340 (position 5 flipped) -> data_o=11'h63A, err_o=1, err_pos_o=5. Counter build: err_cnt_o=1.
- data_i=15'h6351 (parity position 1 flipped) -> data_o=11'h63A, err_o=1, err_pos_o=1.
- Stream 8 back-to-back words, ready_i low for 3 cycles mid-stream -> ready_o drops after 2 words are held. All 8 outputs in order, none lost or duplicated, outputs stable while stalled.
- Counter build: 5 single-error words with CNT_W=2 -> err_cnt_o saturates at 3. cnt_clr_i asserted in the same cycle as an error output -> err_cnt_o=0.
- rst_i pulsed while both stages are full -> valid_o=0 and err_cnt_o=0 immediately. After release, the next input appears exactly 2 cycles after its transfer.
